// File: rtl/core_data_req_buffer.sv
// core_data_req_buffer: decoupling buffer between a cluster core data port and
// its interconnect master port. Core requests are registered in a small FIFO and
// issued in order. The block tracks in-flight requests (queued plus issued but not
// yet answered) so that no more than MAX_OUTSTANDING are ever accepted. Responses
// return in order and are not buffered.
// Optional build macro CORE_DATA_BUF_PERF_EN adds saturating stall and request
// counters (perf_stall_o, perf_req_o).

package core_data_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        we;
    logic [31:0] data;
    logic [3:0]  be;
  } core_data_req_t;

  typedef struct packed {
    logic        gnt;
    logic [31:0] r_data;
    logic        r_valid;
  } core_data_rsp_t;
endpackage

module core_data_req_buffer
  import core_data_pkg::*;
#(
  parameter int DEPTH           = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t core_req_i,
  output core_data_rsp_t core_rsp_o,
  output core_data_req_t mem_req_o,
  input  core_data_rsp_t mem_rsp_i,
  output logic           busy_o,
  output logic           err_o
`ifdef CORE_DATA_BUF_PERF_EN
  ,
  output logic [31:0]    perf_stall_o,
  output logic [31:0]    perf_req_o
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  // OW >= CW because MAX_OUTSTANDING >= DEPTH; one extra bit keeps the sum from wrapping.
  localparam int IW = OW + 1;

  core_data_req_t       fifo_mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        fifo_cnt;
  logic [OW-1:0]        outst_q;
  logic [IW-1:0]        inflight;
  logic                 gnt;
  logic                 push;
  logic                 pop;
  logic                 rsp_ok;
  logic                 fifo_nempty;

  assign fifo_nempty = (fifo_cnt != '0);
  assign inflight    = IW'(fifo_cnt) + IW'(outst_q);

  // Core grant is judged on registered counts only, so a full FIFO never accepts
  // even while it is popping. Grant and response forwarding are masked during
  // reset so nothing is acknowledged that the reset would then discard.
  always_comb begin
    gnt    = core_req_i.req & ~rst_i & (fifo_cnt < CW'(DEPTH)) &
             (inflight < IW'(MAX_OUTSTANDING));
    push   = gnt;
    pop    = fifo_nempty & mem_rsp_i.gnt;
    rsp_ok = mem_rsp_i.r_valid & (outst_q != '0) & ~rst_i;
  end

  // Core-facing response: grant plus in-order response passed straight through.
  always_comb begin
    core_rsp_o         = '0;
    core_rsp_o.gnt     = gnt;
    core_rsp_o.r_data  = mem_rsp_i.r_data;
    core_rsp_o.r_valid = rsp_ok;
  end

  // Interconnect request is the FIFO head, all-zero when nothing is queued.
  always_comb begin
    mem_req_o = '0;
    if (fifo_nempty) begin
      mem_req_o = fifo_mem[rd_ptr];
    end
  end

  assign busy_o = fifo_nempty | (outst_q != '0);

  // FIFO storage; contents need no reset because the count qualifies them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= core_req_i;
    end
  end

  // Pointers, occupancy, outstanding count and the sticky spurious-response flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      outst_q  <= '0;
      err_o    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      outst_q  <= outst_q + OW'(pop) - OW'(rsp_ok);
      if (mem_rsp_i.r_valid && (outst_q == '0)) begin
        err_o <= 1'b1;
      end
    end
  end

`ifdef CORE_DATA_BUF_PERF_EN
  // Saturating counters: cycles the core waited for a grant, and accepted requests.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_o <= '0;
      perf_req_o   <= '0;
    end else begin
      if (core_req_i.req && !gnt && (perf_stall_o != 32'hFFFF_FFFF)) begin
        perf_stall_o <= perf_stall_o + 32'd1;
      end
      if (push && (perf_req_o != 32'hFFFF_FFFF)) begin
        perf_req_o <= perf_req_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_core_data_req_buffer.sv
// Bench for core_data_req_buffer: directed scenarios plus a randomized run, all
// checked every cycle against a queue-based model of the buffer.
module tb_core_data_req_buffer;
  import core_data_pkg::*;

  localparam int DEPTH = 2;
  localparam int MAXO  = 4;

  logic           clk = 1'b0;
  logic           rst;
  core_data_req_t core_req;
  core_data_rsp_t core_rsp;
  core_data_req_t mem_req;
  core_data_rsp_t mem_rsp;
  logic           busy;
  logic           err;
`ifdef CORE_DATA_BUF_PERF_EN
  logic [31:0]    perf_stall;
  logic [31:0]    perf_req;
`endif

  always #5 clk = ~clk;

  core_data_req_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .core_req_i (core_req),
    .core_rsp_o (core_rsp),
    .mem_req_o  (mem_req),
    .mem_rsp_i  (mem_rsp),
    .busy_o     (busy),
    .err_o      (err)
`ifdef CORE_DATA_BUF_PERF_EN
    ,
    .perf_stall_o (perf_stall),
    .perf_req_o   (perf_req)
`endif
  );

  int n_pass  = 0;
  int n_total = 0;

  // Model state: queued requests, issued-but-unanswered count, sticky error.
  core_data_req_t fifo_m[$];
  int             outst_m = 0;
  bit             err_m   = 1'b0;

  // Stimulus state.
  core_data_req_t core_q[$];
  bit             drv_mgnt   = 1'b0;
  bit             drv_rvalid = 1'b0;
  bit             drv_rst    = 1'b0;
  logic [31:0]    drv_rdata  = '0;

  // Observations of the last cycle, for directed literal checks.
  logic        obs_gnt, obs_mreq, obs_rvalid, obs_busy, obs_err;
  logic [31:0] obs_madd, obs_rdata;
  int          n_grants = 0;
  logic [31:0] dut_issued[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic core_data_req_t mk_req(input logic [31:0] add, input logic we);
    core_data_req_t r;
    r.req  = 1'b1;
    r.add  = add;
    r.we   = we;
    r.data = $urandom;
    r.be   = 4'($urandom_range(0, 15));
    return r;
  endfunction

  // One clock cycle: drive, compare against the model, then advance the model.
  task automatic cycle();
    core_data_req_t e;
    bit eg, em, erv, ebusy, do_pop, do_dec;
    int o;
    core_req      = (core_q.size() > 0) ? core_q[0] : '0;
    mem_rsp.gnt     = drv_mgnt;
    mem_rsp.r_valid = drv_rvalid;
    mem_rsp.r_data  = drv_rdata;
    rst           = drv_rst;
    #2;
    o     = outst_m;
    eg    = core_req.req && !drv_rst && (fifo_m.size() < DEPTH) && ((fifo_m.size() + o) < MAXO);
    em    = (fifo_m.size() != 0);
    erv   = drv_rvalid && (o != 0) && !drv_rst;
    ebusy = em || (o != 0);
    e     = em ? fifo_m[0] : '0;
    check("core_gnt", core_rsp.gnt, eg);
    check("core_rvalid", core_rsp.r_valid, erv);
    if (erv) check("core_rdata", core_rsp.r_data, drv_rdata);
    check("mem_req", mem_req.req, em);
    check("mem_add", mem_req.add, e.add);
    check("mem_we_be_data", {mem_req.we, mem_req.be, mem_req.data}, {e.we, e.be, e.data});
    check("busy", busy, ebusy);
    check("err", err, err_m);
    obs_gnt    = core_rsp.gnt;
    obs_mreq   = mem_req.req;
    obs_madd   = mem_req.add;
    obs_rvalid = core_rsp.r_valid;
    obs_rdata  = core_rsp.r_data;
    obs_busy   = busy;
    obs_err    = err;
    if (mem_req.req && drv_mgnt) dut_issued.push_back(mem_req.add);
    if (drv_rst) begin
      fifo_m.delete();
      outst_m = 0;
      err_m   = 1'b0;
    end else begin
      do_pop = em && drv_mgnt;
      do_dec = drv_rvalid && (o != 0);
      if (drv_rvalid && o == 0) err_m = 1'b1;
      if (do_pop) void'(fifo_m.pop_front());
      if (eg) fifo_m.push_back(core_req);
      outst_m = o + int'(do_pop) - int'(do_dec);
    end
    if (core_rsp.gnt && core_q.size() > 0) begin
      void'(core_q.pop_front());
      n_grants++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    drv_rst = 1'b1;
    drv_mgnt = 1'b0;
    drv_rvalid = 1'b0;
    core_q.delete();
    cycle();
    drv_rst = 1'b0;
  endtask

  initial begin
    bit busy_all;
    rst      = 1'b1;
    core_req = '0;
    mem_rsp  = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    cycle();
    check("rst_busy", obs_busy, 1'b0);
    check("rst_err", obs_err, 1'b0);
    check("rst_mreq", obs_mreq, 1'b0);

    // Single read with 0-cycle response path
    drv_mgnt = 1'b1;
    core_q.push_back(mk_req(32'h1000_0010, 1'b0));
    cycle();
    check("t1_gnt", obs_gnt, 1'b1);
    check("t1_no_fallthrough", obs_mreq, 1'b0);
    cycle();
    check("t1_issue", obs_mreq, 1'b1);
    check("t1_add", obs_madd, 32'h1000_0010);
    cycle();
    drv_rvalid = 1'b1;
    drv_rdata  = 32'hDEAD_BEEF;
    cycle();
    check("t1_rvalid", obs_rvalid, 1'b1);
    check("t1_rdata", obs_rdata, 32'hDEAD_BEEF);
    drv_rvalid = 1'b0;
    cycle();
    check("t1_idle", obs_busy, 1'b0);

    // Backpressure: third request held while FIFO full
    do_reset();
    n_grants = 0;
    dut_issued.delete();
    core_q.push_back(mk_req(32'h0000_0A00, 1'b0));
    core_q.push_back(mk_req(32'h0000_0B00, 1'b1));
    core_q.push_back(mk_req(32'h0000_0C00, 1'b0));
    run(4);
    check("t2_grants_held", n_grants, 2);
    check("t2_third_waiting", obs_gnt, 1'b0);
    drv_mgnt = 1'b1;
    run(4);
    check("t2_grants_all", n_grants, 3);
    check("t2_issued_cnt", dut_issued.size(), 3);
    if (dut_issued.size() == 3) begin
      check("t2_order0", dut_issued[0], 32'h0000_0A00);
      check("t2_order1", dut_issued[1], 32'h0000_0B00);
      check("t2_order2", dut_issued[2], 32'h0000_0C00);
    end
    drv_mgnt = 1'b0;
    drv_rvalid = 1'b1;
    run(3);
    drv_rvalid = 1'b0;
    cycle();
    check("t2_drained", obs_busy, 1'b0);

    // Outstanding cap
    do_reset();
    drv_mgnt = 1'b1;
    n_grants = 0;
    for (int i = 0; i < 6; i++) core_q.push_back(mk_req(32'h2000_0000 + 32'(i * 4), 1'b0));
    cycle();
    busy_all = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      busy_all &= obs_busy;
    end
    check("t3_cap_grants", n_grants, 4);
    drv_rvalid = 1'b1;
    cycle();
    busy_all &= obs_busy;
    drv_rvalid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      busy_all &= obs_busy;
    end
    check("t3_one_more", n_grants, 5);
    check("t3_busy", busy_all, 1'b1);

    // Simultaneous issue grant and response keeps outstanding at 2
    do_reset();
    drv_mgnt = 1'b1;
    core_q.push_back(mk_req(32'h3000_0000, 1'b0));
    core_q.push_back(mk_req(32'h3000_0004, 1'b1));
    run(3);
    drv_mgnt = 1'b0;
    core_q.push_back(mk_req(32'h3000_0008, 1'b0));
    run(2);
    drv_mgnt = 1'b1;
    drv_rvalid = 1'b1;
    cycle();
    check("t4_rvalid", obs_rvalid, 1'b1);
    check("t4_issue", obs_madd, 32'h3000_0008);
    drv_rvalid = 1'b0;
    n_grants = 0;
    for (int i = 0; i < 5; i++) core_q.push_back(mk_req(32'h3100_0000 + 32'(i * 4), 1'b0));
    run(8);
    check("t4_room_for_two", n_grants, 2);

    // Spurious response
    do_reset();
    drv_rvalid = 1'b1;
    drv_rdata  = 32'h1234_5678;
    cycle();
    check("t5_dropped", obs_rvalid, 1'b0);
    drv_rvalid = 1'b0;
    cycle();
    check("t5_err", obs_err, 1'b1);
    run(5);
    check("t5_err_sticky", obs_err, 1'b1);
    do_reset();
    cycle();
    check("t5_err_cleared", obs_err, 1'b0);

    // Reset mid-operation
    do_reset();
    drv_mgnt = 1'b1;
    core_q.push_back(mk_req(32'h4000_0000, 1'b0));
    core_q.push_back(mk_req(32'h4000_0004, 1'b0));
    run(3);
    drv_mgnt = 1'b0;
    core_q.push_back(mk_req(32'h4000_0008, 1'b1));
    core_q.push_back(mk_req(32'h4000_000C, 1'b1));
    run(3);
    check("t6_busy_before", obs_busy, 1'b1);
    do_reset();
    core_q.push_back(mk_req(32'h4100_0000, 1'b0));
    cycle();
    check("t6_fresh_gnt", obs_gnt, 1'b1);
    check("t6_mreq_clear", obs_mreq, 1'b0);
    check("t6_busy_clear", obs_busy, 1'b0);
`ifdef CORE_DATA_BUF_PERF_EN
    check("t6_perf_stall", perf_stall, 32'd0);
`endif
    drv_rvalid = 1'b1;
    cycle();
    check("t6_late_dropped", obs_rvalid, 1'b0);
    drv_rvalid = 1'b0;
    cycle();
    check("t6_late_err", obs_err, 1'b1);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (core_q.size() < 3 && $urandom_range(0, 2) == 0)
        core_q.push_back(mk_req($urandom, 1'($urandom_range(0, 1))));
      drv_mgnt   = ($urandom_range(0, 2) != 0);
      drv_rvalid = (outst_m > 0) && ($urandom_range(0, 2) == 0);
      drv_rdata  = $urandom;
      drv_rst    = ($urandom_range(0, 299) == 0);
      cycle();
    end
    drv_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
